// File: rtl/param_counter.sv
`default_nettype none
// ============================================================================
// Module   : param_counter
// Purpose  : Parametrised up/down/ping-pong/one-shot counter for use as a
//            timer or sequencer primitive. The count is clamped to
//            0..MAX_VAL, with a terminal-count pulse and a sticky one-shot
//            completion flag.
// Macro    : COUNTER_PRESCALE_EN - when defined, the count enable is divided
//            by PRESCALE. Steps and tc happen only on prescaler ticks.
// Ports    : i_clk       clock, rising edge
//            i_rst_n     asynchronous active-low reset
//            i_en        count enable
//            i_mode      00 up, 01 down, 10 ping-pong, 11 one-shot up
//            i_load      synchronous load strobe (wins over i_en)
//            i_load_val  load value, clamped to MAX_VAL
//            o_count     registered count
//            o_dir       registered direction, 1 = up
//            o_is_match  o_count == MATCH_VAL (combinational)
//            o_tc        terminal-count pulse (combinational)
//            o_done      registered one-shot completion flag
// Revision : 1.0 - initial release
// ============================================================================
module param_counter #(
    parameter int WIDTH     = 8,
    parameter int MAX_VAL   = 255,
    parameter int MATCH_VAL = 1,
    parameter int PRESCALE  = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic [1:0]       i_mode,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic [WIDTH-1:0] o_count,
    output logic             o_dir,
    output logic             o_is_match,
    output logic             o_tc,
    output logic             o_done
);

    localparam logic [1:0]       c_MODE_UP   = 2'b00;
    localparam logic [1:0]       c_MODE_DOWN = 2'b01;
    localparam logic [1:0]       c_MODE_PING = 2'b10;
    localparam logic [1:0]       c_MODE_ONCE = 2'b11;
    localparam logic [WIDTH-1:0] c_MAX       = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] c_MATCH     = WIDTH'(MATCH_VAL);
    localparam logic [WIDTH-1:0] c_ONE       = WIDTH'(1);

    // An illegal parameter set stops elaboration.
    generate
        if (MAX_VAL < 1 || PRESCALE < 1 || WIDTH < 1) begin : g_param_check
            $error("param_counter: illegal MAX_VAL, PRESCALE or WIDTH");
        end
    endgenerate

    logic [WIDTH-1:0] r_count;
    logic             r_dir;
    logic             r_done;
    logic             w_tick;
    logic [WIDTH-1:0] w_count_nxt;
    logic             w_dir_nxt;
    logic             w_done_nxt;
    logic             w_tc;

`ifdef COUNTER_PRESCALE_EN
    localparam int              c_PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_PW-1:0] c_PRE_LAST = c_PW'(PRESCALE - 1);
    localparam logic [c_PW-1:0] c_PRE_ONE  = c_PW'(1);

    logic [c_PW-1:0] r_pre;

    // The prescaler counts enabled cycles only. A load restarts it so that
    // the first step after a load always comes a full PRESCALE cycles later.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pre <= '0;
        end else if (i_load) begin
            r_pre <= '0;
        end else if (i_en) begin
            r_pre <= (r_pre == c_PRE_LAST) ? '0 : r_pre + c_PRE_ONE;
        end
    end

    assign w_tick = i_en & (r_pre == c_PRE_LAST);
`else
    assign w_tick = i_en;
`endif

    // Next-state and terminal-count decode. tc is high in the cycle that
    // precedes a wrap, turn or finish edge.
    always_comb begin
        w_count_nxt = r_count;
        w_dir_nxt   = r_dir;
        w_done_nxt  = r_done;
        w_tc        = 1'b0;
        if (i_load) begin
            w_count_nxt = (i_load_val > c_MAX) ? c_MAX : i_load_val;
            w_dir_nxt   = 1'b1;
            w_done_nxt  = 1'b0;
        end else if (w_tick) begin
            case (i_mode)
                c_MODE_UP: begin
                    w_tc        = (r_count == c_MAX);
                    w_count_nxt = w_tc ? '0 : r_count + c_ONE;
                end
                c_MODE_DOWN: begin
                    w_tc        = (r_count == '0);
                    w_count_nxt = w_tc ? c_MAX : r_count - c_ONE;
                end
                c_MODE_PING: begin
                    // Turning at an endpoint moves straight to the
                    // neighbour, so each endpoint appears only once.
                    if (r_dir) begin
                        w_tc = (r_count == c_MAX);
                        if (w_tc) begin
                            w_count_nxt = c_MAX - c_ONE;
                            w_dir_nxt   = 1'b0;
                        end else begin
                            w_count_nxt = r_count + c_ONE;
                        end
                    end else begin
                        w_tc = (r_count == '0);
                        if (w_tc) begin
                            w_count_nxt = c_ONE;
                            w_dir_nxt   = 1'b1;
                        end else begin
                            w_count_nxt = r_count - c_ONE;
                        end
                    end
                end
                c_MODE_ONCE: begin
                    if (!r_done) begin
                        if (r_count == c_MAX) begin
                            w_tc       = 1'b1;
                            w_done_nxt = 1'b1;
                        end else begin
                            w_count_nxt = r_count + c_ONE;
                        end
                    end
                end
                default: begin
                    w_count_nxt = r_count;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
            r_dir   <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_dir   <= w_dir_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign o_count    = r_count;
    assign o_dir      = r_dir;
    assign o_done     = r_done;
    assign o_tc       = w_tc;
    assign o_is_match = (r_count == c_MATCH);

endmodule
`default_nettype wire

// File: tb/tb_param_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_param_counter
// Purpose  : Self-checking bench for param_counter (WIDTH=8, MAX_VAL=9,
//            MATCH_VAL=1, PRESCALE=4). A behavioural model is compared with
//            the DUT on every falling edge. Directed sequences carry literal
//            expectations. The prescaler sequence is used when
//            COUNTER_PRESCALE_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_param_counter;

    localparam int WIDTH  = 8;
    localparam int MAXV   = 9;
    localparam int MATCHV = 1;
    localparam int PRESC  = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic [1:0]       mode;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             dir;
    logic             is_match;
    logic             tc;
    logic             done;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    param_counter #(
        .WIDTH     (WIDTH),
        .MAX_VAL   (MAXV),
        .MATCH_VAL (MATCHV),
        .PRESCALE  (PRESC)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_en       (en),
        .i_mode     (mode),
        .i_load     (load),
        .i_load_val (load_val),
        .o_count    (count),
        .o_dir      (dir),
        .o_is_match (is_match),
        .o_tc       (tc),
        .o_done     (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_count;
    int m_dir;
    int m_done;
    int m_pre;

    function automatic bit m_tick();
`ifdef COUNTER_PRESCALE_EN
        return en && (m_pre == PRESC - 1);
`else
        return en;
`endif
    endfunction

    // The event the model is heading for on the next edge decides tc.
    function automatic bit m_tc();
        if (load || !m_tick()) return 1'b0;
        case (mode)
            2'd0:    return m_count == MAXV;
            2'd1:    return m_count == 0;
            2'd2:    return m_dir ? (m_count == MAXV) : (m_count == 0);
            default: return (m_count == MAXV) && !m_done;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_count <= 0;
            m_dir   <= 1;
            m_done  <= 0;
            m_pre   <= 0;
        end else if (load) begin
            m_count <= (int'(load_val) > MAXV) ? MAXV : int'(load_val);
            m_dir   <= 1;
            m_done  <= 0;
            m_pre   <= 0;
        end else begin
            if (en) m_pre <= (m_pre + 1) % PRESC;
            if (m_tick()) begin
                case (mode)
                    2'd0: m_count <= (m_count + 1) % (MAXV + 1);
                    2'd1: m_count <= (m_count + MAXV) % (MAXV + 1);
                    2'd2: begin
                        // Reflect off the endpoint: the next position is the
                        // neighbour on the far side.
                        if (m_dir == 1 && m_count == MAXV) begin
                            m_count <= MAXV - 1; m_dir <= 0;
                        end else if (m_dir == 0 && m_count == 0) begin
                            m_count <= 1; m_dir <= 1;
                        end else begin
                            m_count <= m_count + (m_dir ? 1 : -1);
                        end
                    end
                    default: begin
                        if (m_count == MAXV) m_done <= 1;
                        else if (m_done == 0) m_count <= m_count + 1;
                    end
                endcase
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("cmp_count", 32'(count), 32'(m_count));
            check("cmp_dir", 32'(dir), 32'(m_dir));
            check("cmp_done", 32'(done), 32'(m_done));
            check("cmp_is_match", 32'(is_match), 32'(m_count == MATCHV));
            check("cmp_tc", 32'(tc), 32'(m_tc()));
        end
    end

    // Inputs are applied just after a rising edge and held for the next one.
    task automatic drive(input logic e, input logic [1:0] m, input logic ld,
                         input logic [WIDTH-1:0] lv);
        en = e; mode = m; load = ld; load_val = lv;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; mode = 2'd0; load = 1'b0; load_val = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_count", 32'(count), 0);
        check("rst_dir", 32'(dir), 1);
        check("rst_done", 32'(done), 0);
        check("rst_tc", 32'(tc), 0);
        chk_en = 1'b1;

`ifndef COUNTER_PRESCALE_EN
        // 1: asynchronous reset between edges
        drive(0, 2'd0, 1, 8'd5);
        check("t1_load5", 32'(count), 5);
        drive(1, 2'd3, 0, 8'd0);
        check("t1_pre_rst", 32'(count), 6);
        #2 rst_n = 1'b0;
        #1;
        check("t1_count", 32'(count), 0);
        check("t1_dir", 32'(dir), 1);
        check("t1_done", 32'(done), 0);
        check("t1_is_match", 32'(is_match), 0);
        check("t1_tc", 32'(tc), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // 2: free-run up with wrap
        begin
            int seq2 [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
            drive(0, 2'd0, 1, 8'd0);
            for (int i = 0; i < 12; i++) begin
                drive(1, 2'd0, 0, 8'd0);
                check("t2_count", 32'(count), 32'(seq2[i]));
                check("t2_tc", 32'(tc), 32'(seq2[i] == 9));
                check("t2_match", 32'(is_match), 32'(seq2[i] == 1));
            end
            for (int i = 0; i < 3; i++) begin
                drive(0, 2'd0, 0, 8'd0);
                check("t2_hold", 32'(count), 2);
                check("t2_hold_tc", 32'(tc), 0);
            end
        end

        // 3: ping-pong
        begin
            int seq3 [20] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 1, 2};
            drive(0, 2'd2, 1, 8'd0);
            for (int i = 0; i < 20; i++) begin
                drive(1, 2'd2, 0, 8'd0);
                check("t3_count", 32'(count), 32'(seq3[i]));
                check("t3_dir", 32'(dir), 32'((i < 9) || (i >= 18)));
                check("t3_tc", 32'(tc), 32'((i == 8) || (i == 17)));
            end
        end

        // 4: one-shot
        drive(0, 2'd3, 1, 8'd0);
        for (int i = 1; i <= 9; i++) drive(1, 2'd3, 0, 8'd0);
        check("t4_at_max", 32'(count), 9);
        check("t4_tc", 32'(tc), 1);
        check("t4_not_done", 32'(done), 0);
        drive(1, 2'd3, 0, 8'd0);
        check("t4_done", 32'(done), 1);
        check("t4_tc_after", 32'(tc), 0);
        for (int i = 0; i < 5; i++) begin
            drive(1, 2'd3, 0, 8'd0);
            check("t4_hold", 32'(count), 9);
            check("t4_hold_tc", 32'(tc), 0);
        end
        drive(0, 2'd3, 1, 8'd3);
        check("t4_reload", 32'(count), 3);
        check("t4_reload_done", 32'(done), 0);

        // 5: clamp and load priority
        drive(1, 2'd3, 1, 8'd200);
        check("t5_clamp", 32'(count), 9);
        check("t5_dir", 32'(dir), 1);
        drive(1, 2'd1, 0, 8'd0);
        check("t5_down", 32'(count), 8);
        drive(1, 2'd1, 1, 8'd4);
        check("t5_load_wins", 32'(count), 4);

        // Mode change mid-sequence keeps the ping-pong direction.
        drive(0, 2'd2, 1, 8'd7);
        drive(1, 2'd2, 0, 8'd0);
        drive(1, 2'd2, 0, 8'd0);
        drive(1, 2'd2, 0, 8'd0);
        check("mc_turn", 32'(count), 8);
        check("mc_dir0", 32'(dir), 0);
        drive(1, 2'd0, 0, 8'd0);
        check("mc_up", 32'(count), 9);
        check("mc_dir_kept", 32'(dir), 0);
        drive(1, 2'd0, 0, 8'd0);
        check("mc_wrap", 32'(count), 0);
        drive(1, 2'd2, 0, 8'd0);
        check("mc_pp_turn", 32'(count), 1);
        check("mc_pp_dir", 32'(dir), 1);
`else
        // 6: prescaled stepping
        begin
            int seq6 [8] = '{0, 0, 0, 1, 1, 1, 1, 2};
            drive(0, 2'd0, 1, 8'd0);
            for (int i = 0; i < 8; i++) begin
                drive(1, 2'd0, 0, 8'd0);
                check("t6_count", 32'(count), 32'(seq6[i]));
            end
        end
        drive(0, 2'd0, 1, 8'd0);
        for (int i = 0; i < 5; i++) drive(1, 2'd0, 0, 8'd0);
        check("t6_pre_load", 32'(count), 1);
        drive(1, 2'd0, 1, 8'd7);
        check("t6_load", 32'(count), 7);
        for (int i = 0; i < 3; i++) begin
            drive(1, 2'd0, 0, 8'd0);
            check("t6_restart_hold", 32'(count), 7);
        end
        drive(1, 2'd0, 0, 8'd0);
        check("t6_restart_step", 32'(count), 8);
        drive(0, 2'd0, 1, 8'd9);
        for (int i = 0; i < 3; i++) begin
            drive(1, 2'd0, 0, 8'd0);
            check("t6_tc_wait", 32'(tc), 32'(i == 2));
        end
        drive(1, 2'd0, 0, 8'd0);
        check("t6_wrap", 32'(count), 0);
        drive(0, 2'd0, 0, 8'd0);
        check("t6_hold", 32'(count), 0);
`endif

        @(negedge clk);
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire
